stopwatch_multi: RTL and testbench
==================================

Name: stopwatch_multi

Overview:
Parametrised stopwatch with N BCD digits, each with a selectable modulus (10 or 6). Adds lap/split capture, clear, sticky overflow and per-digit manual set. Takes debounced button levels and drives one active-low 7-segment bus per digit. Sits between the board key conditioning logic and the HEX display pins.

Parameters:
CLK_HZ, 100000000, input clock frequency in Hz
TICK_HZ, 100, LSB digit rate in Hz (100 gives 10 ms resolution); CLK_HZ/TICK_HZ must be an integer >= 2
DIGITS, 6, number of BCD digits; valid range 2..8
MOD6_MASK, 6'b001000, bit i = 1 makes digit i count modulo 6, otherwise modulo 10; width is DIGITS

Ports:
clk100_i  in  1  system clock
rst_i  in  1  synchronous reset, active-high
start_stop_i  in  1  debounced level; rising edge toggles run/stop
set_i  in  1  debounced level; rising edge enters set mode or advances the selected digit
change_i  in  1  debounced level; rising edge increments the selected digit (SET only)
lap_i  in  1  debounced level; rising edge toggles split in RUN, clears the count in STOP/IDLE
cnt_o  out  4*DIGITS  live BCD count; digit i at [4i+3:4i]
hex_o  out  7*DIGITS  displayed value, active-low segments; digit i at [7i+6:7i], bit0=a .. bit6=g
run_o  out  1  1 in RUN
lap_o  out  1  1 while the display is frozen (split)
ovf_o  out  1  sticky wrap indicator
sel_o  out  3  digit selected in SET, otherwise 0

Behaviour:
- Clock and reset: one clock, clk100_i. Reset rst_i is synchronous and active-high.
- Reset values: state=IDLE; all counts 0; divider 0; all edge registers 0; run_o=0, lap_o=0, ovf_o=0, sel_o=0; hex_o shows all zeros (7'b1000000 per digit).
- Edge detection: each key is registered; pulse = level & ~level_q. The effect is registered on the next edge, so outputs change on the 2nd rising edge after a key goes high. A held key produces one pulse only.
- Key priority in a single cycle: rst_i > start_stop > set > lap > change. Lower-priority pulses in the same cycle are dropped.
- States:
  - IDLE: start_stop -> RUN; set -> SET with sel=0; lap -> clear (counts already 0, ovf cleared).
  - RUN: start_stop -> STOP and lap_o cleared; lap toggles lap_o; set and change ignored.
  - STOP: start_stop -> RUN; set -> SET with sel=0; lap -> all counts 0, divider 0, ovf_o=0, state IDLE.
  - SET: set increments sel; when sel = DIGITS-1, set -> STOP with sel=0. change increments digit[sel] by its modulus with no carry. start_stop and lap ignored.
- Divider:
  - Counts 0..CLK_HZ/TICK_HZ-1 only in RUN; holds its value in STOP and SET.
  - tick = (divider at max) & RUN.
  - If the RUN->STOP transition and a tick fall in the same cycle, the tick is applied.
- Counting: on tick, digit0 increments; digit i carries when digit i is at modulus-1 and every lower digit carries.
- Full wrap: when every digit is at max and a tick arrives, all digits go to 0, ovf_o is set, and counting continues.
- Split: lap_o rising loads snap <= live count in the same cycle. While lap_o=1, hex_o decodes snap; otherwise it decodes the live count. cnt_o is always live.
- Decode: combinational from registers; BCD 0-9 only. A mod-6 digit never exceeds 5.
- Widths: divider width = $clog2(CLK_HZ/TICK_HZ). sel compares against DIGITS-1 with no wrap.

Optional Feature:
STOPWATCH_BLINK_EN
- Defined: in SET, the selected digit's hex_o is all-ones (blank) during alternate 250 ms phases, from a free-running counter of CLK_HZ/4 cycles that resets on rst_i and on each set pulse (visible phase first). cnt_o is unaffected.
- Undefined: no blink counter; the selected digit is always shown.

Decomposition:
- Package stopwatch_pkg:
  - state enum (IDLE, RUN, STOP, SET)
  - function mod_of(i)
  - 7-segment constant table SEG_LUT[0:9]
  - SEG_BLANK = 7'h7F
- Sub-module sw_digit:
  - Inputs: clk, rst, clear, inc, set_inc, MOD parameter.
  - Outputs: 4-bit value, carry = inc & (value == MOD-1).
  - Instantiated DIGITS times with a generate loop.
- Top level holds: FSM, divider, edge detect, snapshot register, decode.

Test Plan (CLK_HZ=100, TICK_HZ=10, DIGITS=4, MOD6_MASK=4'b1000):
1. Reset, then start_stop pulse, then 10*123 cycles -> cnt_o=16'h0123, run_o=1.
2. Preload 5999 via SET, then run 10 cycles -> cnt_o=0000, ovf_o=1; lap in STOP -> ovf_o=0 and state IDLE.
3. Run to 0042, lap -> lap_o=1 and hex_o digit0 = SEG(2) while cnt_o keeps advancing; lap again -> hex_o tracks live.
4. SET with sel=3 and 7 change pulses -> digit3=1 (mod 6, no carry into others); 4 set pulses total -> back to STOP, sel_o=0.
5. start_stop and set pulsed in the same cycle from STOP -> RUN only; rst_i asserted mid-RUN -> all outputs at reset values on the next edge.
6. start_stop held high 1000 cycles -> exactly one toggle.

Source files
------------

// File: rtl/stopwatch_pkg.sv
// Shared types, digit modulus helper and 7-segment table for the multi-digit stopwatch.
package stopwatch_pkg;

  typedef enum logic [1:0] {IDLE, RUN, STOP, SET} state_t;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Active-low segments, bit0 = a .. bit6 = g
  localparam logic [6:0] SEG_LUT [0:9] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
    7'h12, 7'h02, 7'h78, 7'h00, 7'h10
  };

  function automatic int mod_of(input logic [7:0] mask, input int i);
    return mask[i] ? 6 : 10;
  endfunction

endpackage

// File: rtl/stopwatch_multi_if.sv
// Key levels and display/status outputs of the stopwatch grouped as one bundle.
interface stopwatch_multi_if #(
  parameter int DIGITS = 6
);
  logic                  start_stop;
  logic                  set;
  logic                  change;
  logic                  lap;
  logic [4*DIGITS-1:0]   cnt;
  logic [7*DIGITS-1:0]   hex;
  logic                  run;
  logic                  lap_flag;
  logic                  ovf;
  logic [2:0]            sel;

  modport master (
    output start_stop, set, change, lap,
    input  cnt, hex, run, lap_flag, ovf, sel
  );

  modport slave (
    input  start_stop, set, change, lap,
    output cnt, hex, run, lap_flag, ovf, sel
  );
endinterface

// File: rtl/sw_digit.sv
// One BCD counter digit with programmable modulus; carry ripples combinationally.
module sw_digit #(
  parameter int MOD = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clear,
  input  logic       inc,
  input  logic       set_inc,
  output logic [3:0] value,
  output logic       carry
);
  localparam logic [3:0] MAXV = 4'(MOD - 1);

  logic [3:0] r_value;
  logic       w_at_max;

  assign w_at_max = (r_value == MAXV);
  assign carry    = inc & w_at_max;
  assign value    = r_value;

  // set_inc wraps the digit alone; the carry output only follows inc
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      r_value <= 4'd0;
    end else if (inc || set_inc) begin
      r_value <= w_at_max ? 4'd0 : r_value + 4'd1;
    end
  end
endmodule

// File: rtl/stopwatch_multi.sv
// Stopwatch top: key edge detect, FSM, tick divider, digit chain, split snapshot, decode.
// Optional STOPWATCH_BLINK_EN blanks the selected digit in alternate 250 ms phases during SET.
module stopwatch_multi
  import stopwatch_pkg::*;
#(
  parameter int              CLK_HZ    = 100000000,
  parameter int              TICK_HZ   = 100,
  parameter int              DIGITS    = 6,
  parameter logic [DIGITS-1:0] MOD6_MASK = DIGITS'(6'b001000)
) (
  input  logic                clk100_i,
  input  logic                rst_i,
  input  logic                start_stop_i,
  input  logic                set_i,
  input  logic                change_i,
  input  logic                lap_i,
  output logic [4*DIGITS-1:0] cnt_o,
  output logic [7*DIGITS-1:0] hex_o,
  output logic                run_o,
  output logic                lap_o,
  output logic                ovf_o,
  output logic [2:0]          sel_o
);
  localparam int             DIV     = CLK_HZ / TICK_HZ;
  localparam int             DW      = $clog2(DIV);
  localparam logic [DW-1:0]  DIV_MAX = DW'(DIV - 1);
  localparam logic [2:0]     SEL_MAX = 3'(DIGITS - 1);

  logic [3:0]          r_lvl;
  logic [3:0]          r_lvl_q;
  logic [3:0]          w_pulse;
  logic                w_ss, w_set, w_lap, w_chg;
  state_t              r_state;
  logic [DW-1:0]       r_div;
  logic                r_lap;
  logic                r_ovf;
  logic [2:0]          r_sel;
  logic [4*DIGITS-1:0] r_snap;
  logic [4*DIGITS-1:0] w_cnt;
  logic [DIGITS:0]     w_inc;
  logic                w_tick;
  logic                w_clear;
  logic                w_blank_sel;

  // Bit order sets priority: start_stop > set > lap > change
  assign w_pulse = r_lvl & ~r_lvl_q;
  assign w_ss    = w_pulse[0];
  assign w_set   = w_pulse[1] & ~w_pulse[0];
  assign w_lap   = w_pulse[2] & ~(|w_pulse[1:0]);
  assign w_chg   = w_pulse[3] & ~(|w_pulse[2:0]);

  assign w_tick   = (r_div == DIV_MAX) && (r_state == RUN);
  assign w_clear  = w_lap && ((r_state == IDLE) || (r_state == STOP));
  assign w_inc[0] = w_tick;

  always_ff @(posedge clk100_i) begin
    if (rst_i) begin
      r_lvl   <= 4'b0;
      r_lvl_q <= 4'b0;
      r_state <= IDLE;
      r_div   <= '0;
      r_lap   <= 1'b0;
      r_ovf   <= 1'b0;
      r_sel   <= 3'd0;
      r_snap  <= '0;
    end else begin
      r_lvl   <= {change_i, lap_i, set_i, start_stop_i};
      r_lvl_q <= r_lvl;

      if (w_clear) begin
        r_div <= '0;
      end else if (r_state == RUN) begin
        r_div <= w_tick ? '0 : r_div + 1'b1;
      end

      if (w_clear) begin
        r_ovf <= 1'b0;
      end else if (w_inc[DIGITS]) begin
        r_ovf <= 1'b1;
      end

      case (r_state)
        IDLE: begin
          if (w_ss) begin
            r_state <= RUN;
          end else if (w_set) begin
            r_state <= SET;
            r_sel   <= 3'd0;
          end
        end
        RUN: begin
          if (w_ss) begin
            r_state <= STOP;
            r_lap   <= 1'b0;
          end else if (w_lap) begin
            r_lap <= ~r_lap;
            if (!r_lap) r_snap <= w_cnt;
          end
        end
        STOP: begin
          if (w_ss) begin
            r_state <= RUN;
          end else if (w_set) begin
            r_state <= SET;
            r_sel   <= 3'd0;
          end else if (w_lap) begin
            r_state <= IDLE;
          end
        end
        SET: begin
          if (w_set) begin
            if (r_sel == SEL_MAX) begin
              r_state <= STOP;
              r_sel   <= 3'd0;
            end else begin
              r_sel <= r_sel + 3'd1;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

`ifdef STOPWATCH_BLINK_EN
  localparam int            BLK = CLK_HZ / 4;
  localparam int            BW  = $clog2(BLK);
  logic [BW-1:0] r_blink_cnt;
  logic          r_blink_hide;

  // Restarting on each set pulse keeps the newly selected digit visible first
  always_ff @(posedge clk100_i) begin
    if (rst_i || w_set) begin
      r_blink_cnt  <= '0;
      r_blink_hide <= 1'b0;
    end else if (r_blink_cnt == BW'(BLK - 1)) begin
      r_blink_cnt  <= '0;
      r_blink_hide <= ~r_blink_hide;
    end else begin
      r_blink_cnt <= r_blink_cnt + 1'b1;
    end
  end

  assign w_blank_sel = r_blink_hide && (r_state == SET);
`else
  assign w_blank_sel = 1'b0;
`endif

  generate
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
      logic [3:0] w_val;
      logic [3:0] w_shown;
      logic [6:0] w_seg;
      logic       w_set_inc;

      assign w_set_inc = w_chg && (r_state == SET) && (r_sel == 3'(gi));

      sw_digit #(
        .MOD (mod_of(8'(MOD6_MASK), gi))
      ) u_digit (
        .clk     (clk100_i),
        .rst     (rst_i),
        .clear   (w_clear),
        .inc     (w_inc[gi]),
        .set_inc (w_set_inc),
        .value   (w_val),
        .carry   (w_inc[gi+1])
      );

      assign w_cnt[4*gi +: 4] = w_val;
      assign w_shown = r_lap ? r_snap[4*gi +: 4] : w_val;
      assign w_seg   = (w_shown <= 4'd9) ? SEG_LUT[w_shown] : SEG_BLANK;
      assign hex_o[7*gi +: 7] = (w_blank_sel && (r_sel == 3'(gi))) ? SEG_BLANK : w_seg;
    end
  endgenerate

  assign cnt_o = w_cnt;
  assign run_o = (r_state == RUN);
  assign lap_o = r_lap;
  assign ovf_o = r_ovf;
  assign sel_o = r_sel;
endmodule

// File: tb/tb_stopwatch_multi.sv
// Directed bench for stopwatch_multi (4 digits, digit3 mod 6, 10 clocks per tick) with a queued scoreboard.
module tb_stopwatch_multi;
  localparam int ND = 4;

  typedef struct {
    string       name;
    logic [15:0] cnt;
    logic [15:0] disp;
    logic        run;
    logic        lap;
    logic        ovf;
    logic [2:0]  sel;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_bad = 0;
  exp_t exp_q[$];
  event chk_ev;

  logic [6:0] seg_tab [0:9];

  stopwatch_multi_if #(.DIGITS(ND)) swi ();

  stopwatch_multi #(
    .CLK_HZ    (100),
    .TICK_HZ   (10),
    .DIGITS    (ND),
    .MOD6_MASK (4'b1000)
  ) dut (
    .clk100_i     (clk),
    .rst_i        (rst),
    .start_stop_i (swi.start_stop),
    .set_i        (swi.set),
    .change_i     (swi.change),
    .lap_i        (swi.lap),
    .cnt_o        (swi.cnt),
    .hex_o        (swi.hex),
    .run_o        (swi.run),
    .lap_o        (swi.lap_flag),
    .ovf_o        (swi.ovf),
    .sel_o        (swi.sel)
  );

  always #5 clk = ~clk;

  function automatic logic [27:0] hex_of(input logic [15:0] v);
    logic [27:0] h;
    h = '0;
    for (int d = 0; d < ND; d++) h[7*d +: 7] = seg_tab[v[4*d +: 4]];
    return h;
  endfunction

  task automatic cmp(input string n, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", n, act, req);
    end
  endtask

  // Monitor: consumes expectations whenever the stimulus flags the outputs as presented
  initial begin
    exp_t e;
    forever begin
      @(chk_ev);
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        cmp({e.name, ".cnt"}, 32'(swi.cnt), 32'(e.cnt));
        cmp({e.name, ".hex"}, 32'(swi.hex), 32'(hex_of(e.disp)));
        cmp({e.name, ".run"}, 32'(swi.run), 32'(e.run));
        cmp({e.name, ".lap"}, 32'(swi.lap_flag), 32'(e.lap));
        cmp({e.name, ".ovf"}, 32'(swi.ovf), 32'(e.ovf));
        cmp({e.name, ".sel"}, 32'(swi.sel), 32'(e.sel));
        $display("check %s cnt=%h run=%b lap=%b ovf=%b sel=%0d", e.name, swi.cnt, swi.run,
                 swi.lap_flag, swi.ovf, swi.sel);
      end
    end
  end

  task automatic expect_st(input string n, input logic [15:0] c, input logic [15:0] d,
                           input logic r, input logic l, input logic o, input logic [2:0] s);
    exp_t e;
    e.name = n; e.cnt = c; e.disp = d; e.run = r; e.lap = l; e.ovf = o; e.sel = s;
    exp_q.push_back(e);
    -> chk_ev;
    #1;
  endtask

  task automatic wait_n(input int n);
    repeat (n) @(negedge clk);
  endtask

  // key: 0 start_stop, 1 set, 2 lap, 3 change; effect visible after return
  task automatic press(input int key);
    case (key)
      0: swi.start_stop = 1'b1;
      1: swi.set        = 1'b1;
      2: swi.lap        = 1'b1;
      default: swi.change = 1'b1;
    endcase
    @(negedge clk);
    swi.start_stop = 1'b0; swi.set = 1'b0; swi.lap = 1'b0; swi.change = 1'b0;
    @(negedge clk);
  endtask

  task automatic press_n(input int key, input int n);
    for (int k = 0; k < n; k++) press(key);
  endtask

  initial begin
    seg_tab[0] = 7'b1000000; seg_tab[1] = 7'b1111001; seg_tab[2] = 7'b0100100;
    seg_tab[3] = 7'b0110000; seg_tab[4] = 7'b0011001; seg_tab[5] = 7'b0010010;
    seg_tab[6] = 7'b0000010; seg_tab[7] = 7'b1111000; seg_tab[8] = 7'b0000000;
    seg_tab[9] = 7'b0010000;
    swi.start_stop = 1'b0; swi.set = 1'b0; swi.lap = 1'b0; swi.change = 1'b0;
    wait_n(3);
    expect_st("reset", 16'h0000, 16'h0000, 0, 0, 0, 3'd0);
    rst = 1'b0;
    wait_n(1);

    // 1: run 123 ticks
    press(0);
    wait_n(1230);
    expect_st("run123", 16'h0123, 16'h0123, 1, 0, 0, 3'd0);

    // 2: stop, clear, preload 5999, wrap
    press(0);
    expect_st("stop123", 16'h0123, 16'h0123, 0, 0, 0, 3'd0);
    press(2);
    expect_st("clear", 16'h0000, 16'h0000, 0, 0, 0, 3'd0);
    press(1);
    press_n(3, 9);
    press(1);
    press_n(3, 9);
    press(1);
    press_n(3, 9);
    press(1);
    press_n(3, 5);
    expect_st("preload", 16'h5999, 16'h5999, 0, 0, 0, 3'd3);
    press(1);
    expect_st("set_exit", 16'h5999, 16'h5999, 0, 0, 0, 3'd0);
    press(0);
    wait_n(9);
    expect_st("prewrap", 16'h5999, 16'h5999, 1, 0, 0, 3'd0);
    wait_n(1);
    expect_st("wrap", 16'h0000, 16'h0000, 1, 0, 1, 3'd0);
    press(0);
    expect_st("ovf_sticky", 16'h0000, 16'h0000, 0, 0, 1, 3'd0);
    press(2);
    expect_st("ovf_clear", 16'h0000, 16'h0000, 0, 0, 0, 3'd0);

    // 3: split
    press(0);
    wait_n(420);
    press(2);
    expect_st("split_on", 16'h0042, 16'h0042, 1, 1, 0, 3'd0);
    wait_n(100);
    expect_st("split_hold", 16'h0052, 16'h0042, 1, 1, 0, 3'd0);
    press(2);
    expect_st("split_off", 16'h0052, 16'h0052, 1, 0, 0, 3'd0);

    // 4: set digit3 mod 6 without carry
    press(0);
    press(1);
    expect_st("set_enter", 16'h0052, 16'h0052, 0, 0, 0, 3'd0);
    press_n(1, 3);
    press_n(3, 7);
    expect_st("set_d3", 16'h1052, 16'h1052, 0, 0, 0, 3'd3);
    press(1);
    expect_st("set_done", 16'h1052, 16'h1052, 0, 0, 0, 3'd0);

    // 5: simultaneous start_stop + set from STOP, then reset mid-run
    swi.start_stop = 1'b1; swi.set = 1'b1;
    @(negedge clk);
    swi.start_stop = 1'b0; swi.set = 1'b0;
    @(negedge clk);
    expect_st("prio", 16'h1052, 16'h1052, 1, 0, 0, 3'd0);
    wait_n(3);
    rst = 1'b1;
    wait_n(1);
    expect_st("mid_rst", 16'h0000, 16'h0000, 0, 0, 0, 3'd0);
    rst = 1'b0;
    wait_n(1);

    // 6: held key toggles once
    swi.start_stop = 1'b1;
    wait_n(1000);
    swi.start_stop = 1'b0;
    wait_n(2);
    expect_st("held", 16'h0100, 16'h0100, 1, 0, 0, 3'd0);

    #2;
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
